ex_issue: RTL and testbench

EX_ISSUE -- requirements
Module: ex_issue

---
 rtl/p_hardisc.sv | 29 ++
 rtl/exi_watchdog.sv | 33 +++
 rtl/ex_issue.sv | 151 +++++++++++++++
 tb/tb_ex_issue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_hardisc.sv
// Shared types and constants for the hardisc pipeline stages.
// Holds instruction-control and function encodings plus the EX issue FSM state type.
package p_hardisc;

   localparam int unsigned DATA_W          = 32;
   localparam int unsigned PC_W            = 31;
   localparam int unsigned PAYLOAD_W       = 21;
   localparam int unsigned ICTRL_W         = 7;
   localparam int unsigned FPART_W         = 4;
   localparam int unsigned ICTRL_UNIT_MDU  = 4;
   localparam int unsigned EXI_CNT_W       = 8;
   localparam int unsigned EXI_MDU_TIMEOUT = 40;

   typedef logic [ICTRL_W-1:0] ictrl;
   typedef logic [FPART_W-1:0] f_part;

   typedef enum logic [1:0] {
      EXI_IDLE = 2'd0,
      EXI_EXEC = 2'd1,
      EXI_WAIT = 2'd2
   } exi_state_t;

   // Result/PC pair handed from EX to MA
   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [PC_W-1:0]   pc;
   } exi_ma_t;

endpackage

// File: rtl/exi_watchdog.sv
// Cycle counter for a multi-cycle MDU op: load, increment (saturating), freeze.
// Flags when the count reaches LIMIT-1 so the issuing stage can abort the op.
module exi_watchdog
   import p_hardisc::*;
#(
   parameter int unsigned LIMIT = EXI_MDU_TIMEOUT
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_clear,
   input  logic i_load,
   input  logic i_inc,
   input  logic i_freeze,
   output logic o_expired_c
);

   logic [EXI_CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= EXI_CNT_W'(1);
      end else if (i_inc && !i_freeze && (r_count != '1)) begin
         r_count <= r_count + EXI_CNT_W'(1);
      end
   end

   assign o_expired_c = (r_count == EXI_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ex_issue.sv
// EX-stage issue control: holds one instruction for the executor, waits on MDU ops
// with a timeout watchdog, and registers the result toward the MA stage.
module ex_issue
   import p_hardisc::*;
#(
   parameter int unsigned MDU_TIMEOUT = EXI_MDU_TIMEOUT
) (
   input  logic                 s_clk_i,
   input  logic                 s_resetn_i,
   input  logic                 s_flush_i,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
   input  logic [ICTRL_W-1:0]   s_ictrl_i,
   input  logic [FPART_W-1:0]   s_function_i,
   input  logic [DATA_W-1:0]    s_operand1_i,
   input  logic [DATA_W-1:0]    s_operand2_i,
   input  logic [PAYLOAD_W-1:0] s_payload_i,
   input  logic [PC_W-1:0]      s_pc_i,
   output logic [ICTRL_W-1:0]   s_ex_ictrl_o,
   output logic [FPART_W-1:0]   s_ex_function_o,
   output logic [DATA_W-1:0]    s_ex_op1_o,
   output logic [DATA_W-1:0]    s_ex_op2_o,
   output logic [PAYLOAD_W-1:0] s_ex_payload_o,
   output logic [PC_W-1:0]      s_ex_pc_o,
   output logic                 s_ex_stall_o,
   output logic                 s_ex_flush_o,
   input  logic                 s_ex_finished_i,
   input  logic [DATA_W-1:0]    s_ex_result_i,
   output logic                 s_ma_valid_o,
   input  logic                 s_ma_ready_i,
   output logic [DATA_W-1:0]    s_ma_result_o,
   output logic [PC_W-1:0]      s_ma_pc_o,
   output logic                 s_error_o
);

   exi_state_t r_state, w_next;

   ictrl                 r_ictrl;
   f_part                r_func;
   logic [DATA_W-1:0]    r_op1, r_op2;
   logic [PAYLOAD_W-1:0] r_payload;
   logic [PC_W-1:0]      r_pc;
   logic                 r_ma_valid;
   exi_ma_t              r_ma;

   logic w_mdu, w_accept, w_complete, w_capture, w_timeout, w_ready, w_xfer;
   logic w_stall, w_wd_load, w_wd_inc, w_wd_clear, w_expired;

   assign w_mdu    = r_ictrl[ICTRL_UNIT_MDU];
   assign w_accept = !r_ma_valid || s_ma_ready_i;
   assign w_stall  = s_resetn_i && (r_state != EXI_IDLE) && r_ma_valid && !s_ma_ready_i;

   always_ff @(posedge s_clk_i) begin
      if (!s_resetn_i) r_state <= EXI_IDLE;
      else             r_state <= w_next;
   end

   // Next state, completion, handshake and watchdog control
   always_comb begin
      w_next     = r_state;
      w_complete = 1'b0;
      w_timeout  = 1'b0;
      w_wd_load  = 1'b0;
      w_wd_inc   = 1'b0;
      case (r_state)
         EXI_IDLE: w_next = EXI_IDLE;
         EXI_EXEC: begin
            w_complete = !w_mdu || s_ex_finished_i;
            if (!w_complete) begin
               w_next    = EXI_WAIT;
               w_wd_load = 1'b1;
            end
         end
         EXI_WAIT: begin
            w_complete = s_ex_finished_i;
            if (!w_complete) begin
               if (w_expired) begin
                  w_timeout = s_resetn_i && !s_flush_i;
                  w_next    = EXI_IDLE;
               end else begin
                  w_wd_inc = 1'b1;
               end
            end
         end
         default: w_next = EXI_IDLE;
      endcase
      w_capture = w_complete && w_accept && !s_flush_i && s_resetn_i;
      w_ready   = s_resetn_i && !s_flush_i && ((r_state == EXI_IDLE) || w_capture);
      w_xfer    = s_valid_i && w_ready;
      if (w_capture || (r_state == EXI_IDLE)) w_next = w_xfer ? EXI_EXEC : EXI_IDLE;
      if (s_flush_i) w_next = EXI_IDLE;
      w_wd_clear = s_flush_i || (w_next != EXI_WAIT);
   end

   exi_watchdog #(
      .LIMIT (MDU_TIMEOUT)
   ) u_watchdog (
      .i_clk       (s_clk_i),
      .i_rstn      (s_resetn_i),
      .i_clear     (w_wd_clear),
      .i_load      (w_wd_load),
      .i_inc       (w_wd_inc),
      .i_freeze    (w_stall),
      .o_expired_c (w_expired)
   );

   // Instruction payload only moves on a transfer; ictrl is reset so an empty stage reads as no-op
   always_ff @(posedge s_clk_i) begin
      if (!s_resetn_i)  r_ictrl <= '0;
      else if (w_xfer)  r_ictrl <= s_ictrl_i;
   end

   always_ff @(posedge s_clk_i) begin
      if (w_xfer) begin
         r_func    <= s_function_i;
         r_op1     <= s_operand1_i;
         r_op2     <= s_operand2_i;
         r_payload <= s_payload_i;
         r_pc      <= s_pc_i;
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (!s_resetn_i) begin
         r_ma_valid <= 1'b0;
         r_ma       <= '0;
      end else if (s_flush_i) begin
         r_ma_valid <= 1'b0;
      end else if (w_capture) begin
         r_ma_valid <= 1'b1;
         r_ma       <= '{result: s_ex_result_i, pc: r_pc};
      end else if (s_ma_ready_i) begin
         r_ma_valid <= 1'b0;
      end
   end

   assign s_ready_o       = w_ready;
   assign s_ex_ictrl_o    = (r_state == EXI_IDLE) ? '0 : r_ictrl;
   assign s_ex_function_o = r_func;
   assign s_ex_op1_o      = r_op1;
   assign s_ex_op2_o      = r_op2;
   assign s_ex_payload_o  = r_payload;
   assign s_ex_pc_o       = r_pc;
   assign s_ex_stall_o    = w_stall;
   assign s_ex_flush_o    = s_resetn_i && (s_flush_i || w_timeout);
   assign s_error_o       = w_timeout;
   assign s_ma_valid_o    = r_ma_valid;
   assign s_ma_result_o   = r_ma.result;
   assign s_ma_pc_o       = r_ma.pc;

endmodule

// File: tb/tb_ex_issue.sv
// Directed bench for ex_issue with a small executor model (result = op1 ^ op2)
// and a result/PC scoreboard drained on each MA handshake.
module tb_ex_issue;
   import p_hardisc::*;

   localparam int unsigned TMO = 40;

   logic                 clk = 1'b0;
   logic                 resetn, flush, valid, ready;
   logic [ICTRL_W-1:0]   ictrl_i, ex_ictrl;
   logic [FPART_W-1:0]   func_i, ex_func;
   logic [DATA_W-1:0]    op1_i, op2_i, ex_op1, ex_op2, ex_result;
   logic [PAYLOAD_W-1:0] payload_i, ex_payload;
   logic [PC_W-1:0]      pc_i, ex_pc, ma_pc;
   logic                 ex_stall, ex_flush, ex_finished;
   logic                 ma_valid, ma_ready, error;
   logic [DATA_W-1:0]    ma_result;

   exi_ma_t sb_q[$];
   int      n_cmp = 0;
   int      n_mis = 0;

   always #5 clk = ~clk;

   // Executor model
   assign ex_result = ex_op1 ^ ex_op2;

   ex_issue #(.MDU_TIMEOUT(TMO)) dut (
      .s_clk_i         (clk),
      .s_resetn_i      (resetn),
      .s_flush_i       (flush),
      .s_valid_i       (valid),
      .s_ready_o       (ready),
      .s_ictrl_i       (ictrl_i),
      .s_function_i    (func_i),
      .s_operand1_i    (op1_i),
      .s_operand2_i    (op2_i),
      .s_payload_i     (payload_i),
      .s_pc_i          (pc_i),
      .s_ex_ictrl_o    (ex_ictrl),
      .s_ex_function_o (ex_func),
      .s_ex_op1_o      (ex_op1),
      .s_ex_op2_o      (ex_op2),
      .s_ex_payload_o  (ex_payload),
      .s_ex_pc_o       (ex_pc),
      .s_ex_stall_o    (ex_stall),
      .s_ex_flush_o    (ex_flush),
      .s_ex_finished_i (ex_finished),
      .s_ex_result_i   (ex_result),
      .s_ma_valid_o    (ma_valid),
      .s_ma_ready_i    (ma_ready),
      .s_ma_result_o   (ma_result),
      .s_ma_pc_o       (ma_pc),
      .s_error_o       (error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      exi_ma_t e;
      if (ma_valid && ma_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_spurious_valid", 64'(ma_valid), 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_result", 64'(ma_result), 64'(e.result));
            chk("sb_pc", 64'(ma_pc), 64'(e.pc));
         end
      end
   endtask

   task automatic settle();
      #2;
      monitor();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [ICTRL_W-1:0] ic, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic [PC_W-1:0] pc);
      valid     = 1'b1;
      ictrl_i   = ic;
      func_i    = FPART_W'($urandom);
      op1_i     = a;
      op2_i     = b;
      payload_i = PAYLOAD_W'($urandom);
      pc_i      = pc;
   endtask

   task automatic push(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [PC_W-1:0] pc);
      sb_q.push_back('{result: a ^ b, pc: pc});
   endtask

   initial begin
      logic [ICTRL_W-1:0] alu, mdu;
      logic [DATA_W-1:0]  a [3];
      logic [DATA_W-1:0]  b [3];
      logic [PC_W-1:0]    p [3];

      alu = ICTRL_W'(1);
      mdu = ICTRL_W'(1) << ICTRL_UNIT_MDU;
      resetn = 1'b0; flush = 1'b0; valid = 1'b0; ictrl_i = '0; func_i = '0;
      op1_i = '0; op2_i = '0; payload_i = '0; pc_i = '0;
      ex_finished = 1'b0; ma_ready = 1'b1;

      // Reset values
      tick(); tick();
      settle();
      chk("rst_ma_valid", 64'(ma_valid), 64'd0);
      chk("rst_ictrl", 64'(ex_ictrl), 64'd0);
      chk("rst_result", 64'(ma_result), 64'd0);
      chk("rst_pc", 64'(ma_pc), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_flush", 64'(ex_flush), 64'd0);
      chk("rst_stall", 64'(ex_stall), 64'd0);
      resetn = 1'b1;
      settle();
      chk("idle_ready", 64'(ready), 64'd1);
      tick();

      // Back-to-back ALU ops
      for (int i = 0; i < 3; i++) begin
         a[i] = $urandom; b[i] = $urandom; p[i] = PC_W'(32'h100 + 4 * i);
         issue(alu, a[i], b[i], p[i]);
         push(a[i], b[i], p[i]);
         settle();
         chk("alu_ready", 64'(ready), 64'd1);
         if (i > 0) chk("alu_ex_pc", 64'(ex_pc), 64'(p[i-1]));
         if (i == 2) chk("alu_latency", 64'(ma_valid), 64'd1);
         tick();
      end
      valid = 1'b0;
      for (int j = 0; j < 2; j++) begin
         settle();
         chk("alu_ma_valid", 64'(ma_valid), 64'd1);
         tick();
      end
      settle();
      chk("alu_ma_drop", 64'(ma_valid), 64'd0);
      chk("alu_sb_drain", 64'(sb_q.size()), 64'd0);
      tick();

      // MDU op finishing 5 cycles after issue
      issue(mdu, 32'hDEAD_0001, 32'h0000_BEEF, PC_W'(32'h200));
      push(32'hDEAD_0001, 32'h0000_BEEF, PC_W'(32'h200));
      settle();
      tick();
      valid = 1'b0;
      for (int k = 1; k < 5; k++) begin
         settle();
         chk("mdu_ready_low", 64'(ready), 64'd0);
         chk("mdu_no_valid", 64'(ma_valid), 64'd0);
         tick();
      end
      ex_finished = 1'b1;
      settle();
      chk("mdu_done_ready", 64'(ready), 64'd1);
      tick();
      ex_finished = 1'b0;
      settle();
      chk("mdu_ma_valid", 64'(ma_valid), 64'd1);
      tick();
      settle();
      chk("mdu_ma_drop", 64'(ma_valid), 64'd0);
      tick();

      // Back-pressure from MA stalls the executor
      issue(alu, 32'h1111_0000, 32'h0000_2222, PC_W'(32'h300));
      push(32'h1111_0000, 32'h0000_2222, PC_W'(32'h300));
      ma_ready = 1'b0;
      settle();
      chk("stl_ready0", 64'(ready), 64'd1);
      tick();
      issue(alu, 32'h3333_0000, 32'h0000_4444, PC_W'(32'h304));
      push(32'h3333_0000, 32'h0000_4444, PC_W'(32'h304));
      settle();
      chk("stl_ready1", 64'(ready), 64'd1);
      tick();
      issue(alu, 32'h5555_0000, 32'h0000_6666, PC_W'(32'h308));
      push(32'h5555_0000, 32'h0000_6666, PC_W'(32'h308));
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("stl_stall", 64'(ex_stall), 64'd1);
         chk("stl_ready", 64'(ready), 64'd0);
         chk("stl_hold", 64'(ma_result), 64'h1111_2222);
         tick();
      end
      ma_ready = 1'b1;
      settle();
      chk("stl_release", 64'(ready), 64'd1);
      chk("stl_unstall", 64'(ex_stall), 64'd0);
      tick();
      valid = 1'b0;
      settle(); tick();
      settle(); tick();
      settle();
      chk("stl_ma_drop", 64'(ma_valid), 64'd0);
      chk("stl_sb_drain", 64'(sb_q.size()), 64'd0);
      tick();

      // MDU op that never finishes
      issue(mdu, 32'h0BAD_0BAD, 32'h1, PC_W'(32'h400));
      settle();
      tick();
      valid = 1'b0;
      for (int k = 1; k < int'(TMO); k++) begin
         settle();
         chk("tmo_no_error", 64'(error), 64'd0);
         chk("tmo_no_valid", 64'(ma_valid), 64'd0);
         tick();
      end
      settle();
      chk("tmo_error", 64'(error), 64'd1);
      chk("tmo_flush", 64'(ex_flush), 64'd1);
      chk("tmo_ready", 64'(ready), 64'd0);
      tick();
      settle();
      chk("tmo_error_pulse", 64'(error), 64'd0);
      chk("tmo_flush_pulse", 64'(ex_flush), 64'd0);
      chk("tmo_idle_ictrl", 64'(ex_ictrl), 64'd0);
      chk("tmo_no_capture", 64'(ma_valid), 64'd0);
      chk("tmo_idle_ready", 64'(ready), 64'd1);
      tick();

      // Flush coincident with finish and a new valid
      issue(mdu, 32'h7, 32'h8, PC_W'(32'h500));
      settle(); tick();
      valid = 1'b0;
      settle(); tick();
      ex_finished = 1'b1; flush = 1'b1;
      issue(alu, 32'h9, 32'hA, PC_W'(32'h504));
      settle();
      chk("fl_ready", 64'(ready), 64'd0);
      chk("fl_ex_flush", 64'(ex_flush), 64'd1);
      chk("fl_error", 64'(error), 64'd0);
      tick();
      ex_finished = 1'b0; flush = 1'b0; valid = 1'b0;
      settle();
      chk("fl_no_capture", 64'(ma_valid), 64'd0);
      chk("fl_no_xfer", 64'(ex_ictrl), 64'd0);
      chk("fl_idle_ready", 64'(ready), 64'd1);
      tick();

      // Reset during WAIT
      issue(mdu, 32'hC, 32'hD, PC_W'(32'h600));
      settle(); tick();
      valid = 1'b0;
      settle(); tick();
      settle(); tick();
      resetn = 1'b0;
      settle();
      chk("rw_flush", 64'(ex_flush), 64'd0);
      chk("rw_stall", 64'(ex_stall), 64'd0);
      chk("rw_error", 64'(error), 64'd0);
      tick();
      resetn = 1'b1;
      settle();
      chk("rw_ictrl", 64'(ex_ictrl), 64'd0);
      chk("rw_ma_valid", 64'(ma_valid), 64'd0);
      chk("rw_result", 64'(ma_result), 64'd0);
      chk("rw_pc", 64'(ma_pc), 64'd0);
      chk("rw_ready", 64'(ready), 64'd1);
      tick();
      for (int k = 0; k < int'(TMO) + 5; k++) begin
         settle();
         chk("rw_no_error", 64'(error), 64'd0);
         tick();
      end
      chk("final_sb_drain", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
